rmap_bus_memory: RTL
====================

// Module: rmap_bus_memory
// PURPOSE
//  Bus slave directly downstream of the RMAP target's internal bus master port.
//  - Serves RMAP write/read/RMW word accesses from a byte-enabled on-chip RAM covering [ADDR_MIN, ADDR_MAX).
//  - Inserts programmable wait states.
//  - Signals a bus time-out error for out-of-range or malformed accesses, so the RMAP target can report them.
// PARAMETERS
//  ADDR_MIN        0     byte base address; multiple of 4
//  ADDR_MAX        2048  byte end address (exclusive); multiple of 4, > ADDR_MIN
//  BUS_WIDTH       32    data width; multiple of 8
//  WAIT_STATES     0     extra cycles between accept and ack (0..15)
//  TIMEOUT_CYCLES  64    cycles from accept to time-out pulse; must be > WAIT_STATES+1
// PORTS
//  clk                 in   1            clock
//  rst                 in   1            synchronous reset, active-high
//  busCycleIn          in   1            bus cycle active
//  busStrobeIn         in   1            access request, held until ack/time-out
//  busAddressIn        in   32           byte address
//  busByteEnableIn     in   BUS_WIDTH/8  byte lane enables for writes
//  busDataIn           in   BUS_WIDTH    write data
//  busWriteEnableIn    in   1            write access
//  busReadEnableIn     in   1            read access
//  busDataOut          out  BUS_WIDTH    read data, valid in ack cycle, held until next read ack
//  busAcknowledgeOut   out  1            one-cycle ack pulse
//  busTimeOutErrorOut  out  1            one-cycle time-out pulse
// BEHAVIOUR
//  - Reset: busDataOut=0, busAcknowledgeOut=0, busTimeOutErrorOut=0, FSM=IDLE, counters=0.
//    RAM contents are not cleared.
//  - Word index = (busAddressIn-ADDR_MIN)>>2.
//    Bits [1:0] are ignored; lane selection is by byte enables only.
//  - Accept condition, sampled in IDLE: busCycleIn & busStrobeIn.
//  - Valid access: exactly one of write/read enable, and ADDR_MIN <= addr < ADDR_MAX.
//  - FSM:
//    IDLE -> WAIT on a valid access; counter=0.
//    IDLE -> ERR on an invalid access (both/neither enable, or out of range).
//    WAIT: counter++. When counter==WAIT_STATES -> ACK.
//    ACK: busAcknowledgeOut=1 for exactly this cycle.
//      Write: commit enabled lanes at this edge.
//      Read: busDataOut <= RAM word, visible in the ack cycle.
//      Next state IDLE; a new access may be accepted in the following cycle (back-to-back).
//    ERR: counter++. When counter==TIMEOUT_CYCLES-1, busTimeOutErrorOut=1 for one cycle -> IDLE.
//      No RAM access; busDataOut unchanged.
//  - Latency: accept in cycle 0 -> ack in cycle 1+WAIT_STATES; time-out in cycle TIMEOUT_CYCLES.
//  - Ack and time-out are never asserted together.
//  - Abort: busCycleIn or busStrobeIn low in WAIT/ERR -> IDLE next cycle.
//    No write, no ack, no time-out.
//  - Write with busByteEnableIn==0: acked, RAM unchanged.
//  - Reset mid-access: dominates; no write occurs, outputs go to reset values next edge.
//  - RAM is synchronous read, 1-cycle latency. The read is issued on the WAIT->ACK transition,
//    so read data is valid in the ack cycle.
// STRUCTURE
//  - Package rmap_bus_pkg:
//    bus_state_t enum {IDLE, WAIT, ACK, ERR};
//    function addr_in_range(addr, min, max);
//    localparam WORDS=(ADDR_MAX-ADDR_MIN)/4, IDX_W=$clog2(WORDS).
//  - Sub-module rmap_bus_ram: single-port, BUS_WIDTH/8 byte-lane write enables, registered read.
//  - Top module contains the FSM, counters and output registers.
// TESTING
//  1. Write 0xDEADBEEF @0x10, BE=4'hF, WAIT_STATES=0 -> ack in cycle 1.
//     Then read @0x10 -> busDataOut=0xDEADBEEF in its ack cycle.
//  2. Write 0x000000AA @0x20 with BE=4'h1 over prior 0x11223344 -> read returns 0x112233AA.
//  3. WAIT_STATES=3, read @0x0 -> ack exactly 4 cycles after accept, single-cycle pulse.
//  4. Read @0x800 (=ADDR_MAX) -> no ack; busTimeOutErrorOut pulses at cycle 64; RAM unchanged.
//     Same for read+write both high @0x4.
//  5. Write @0x30, drop busCycleIn in WAIT (WAIT_STATES=3) -> no ack; read @0x30 returns old value.
//  6. Back-to-back: 8 incrementing writes @0x40..0x5C with strobe re-asserted the cycle after each ack
//     -> 8 acks; read-back matches; rst pulse mid-stream -> outputs 0 next cycle.

Source files
------------

// File: rtl/rmap_bus_pkg.sv
// Shared types and helpers for the RMAP bus memory slave.
package rmap_bus_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} bus_state_t;

    localparam int unsigned DEFAULT_ADDR_MIN = 0;
    localparam int unsigned DEFAULT_ADDR_MAX = 2048;
    localparam int unsigned WORDS = (DEFAULT_ADDR_MAX - DEFAULT_ADDR_MIN) / 4;
    localparam int unsigned IDX_W = $clog2(WORDS);

    function automatic int unsigned wordCount(input int unsigned addrMin,
                                              input int unsigned addrMax);
        return (addrMax - addrMin) / 4;
    endfunction

    // Keeps a one-word memory from collapsing to a zero-width index.
    function automatic int unsigned indexWidth(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] addrMin,
                                           input logic [31:0] addrMax);
        return (addr >= addrMin) && (addr < addrMax);
    endfunction

endpackage

// File: rtl/rmap_bus_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
module rmap_bus_ram #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned WORDS     = 512,
    parameter int unsigned INDEX_W   = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_W-1:0]     index,
    input  logic                   writeEnable,
    input  logic [BUS_WIDTH/8-1:0] byteEnable,
    input  logic [BUS_WIDTH-1:0]   writeData,
    input  logic                   readEnable,
    output logic [BUS_WIDTH-1:0]   readData
);

    localparam int unsigned LANES = BUS_WIDTH / 8;

    logic [BUS_WIDTH-1:0] mem [WORDS];

    // The array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (writeEnable) begin
            for (int unsigned lane = 0; lane < LANES; lane++) begin
                if (byteEnable[lane]) begin
                    mem[index][lane*8 +: 8] <= writeData[lane*8 +: 8];
                end
            end
        end
    end

    // Read data is only refreshed on a read, so it holds between read acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            readData <= '0;
        end else if (readEnable) begin
            readData <= mem[index];
        end
    end

endmodule

// File: rtl/rmap_bus_memory.sv
// RMAP target bus slave: byte-enabled RAM with programmable wait states and
// a time-out error response for out-of-range or malformed accesses.
module rmap_bus_memory
    import rmap_bus_pkg::*;
#(
    parameter int unsigned ADDR_MIN       = DEFAULT_ADDR_MIN,
    parameter int unsigned ADDR_MAX       = DEFAULT_ADDR_MAX,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   busCycleIn,
    input  logic                   busStrobeIn,
    input  logic [31:0]            busAddressIn,
    input  logic [BUS_WIDTH/8-1:0] busByteEnableIn,
    input  logic [BUS_WIDTH-1:0]   busDataIn,
    input  logic                   busWriteEnableIn,
    input  logic                   busReadEnableIn,
    output logic [BUS_WIDTH-1:0]   busDataOut,
    output logic                   busAcknowledgeOut,
    output logic                   busTimeOutErrorOut
);

    localparam int unsigned NUM_WORDS = wordCount(ADDR_MIN, ADDR_MAX);
    localparam int unsigned INDEX_W   = indexWidth(NUM_WORDS);
    localparam int unsigned LANES     = BUS_WIDTH / 8;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             DIRECT_ACK = (WAIT_STATES == 0);

    bus_state_t           state;
    logic [CNT_W-1:0]     counter;
    logic [INDEX_W-1:0]   indexReg;
    logic                 isReadReg;
    logic [LANES-1:0]     byteEnableReg;
    logic [BUS_WIDTH-1:0] writeDataReg;
    logic                 ackReg;
    logic                 timeOutReg;

    logic                 active;
    logic                 validReq;
    logic [INDEX_W-1:0]   reqIndex;
    logic [INDEX_W-1:0]   ramIndex;
    logic                 ramReadEnable;
    logic                 ramWriteEnable;

    assign active   = busCycleIn & busStrobeIn;
    assign validReq = (busWriteEnableIn ^ busReadEnableIn)
                    & addr_in_range(busAddressIn, 32'(ADDR_MIN), 32'(ADDR_MAX));
    assign reqIndex = INDEX_W'((busAddressIn - 32'(ADDR_MIN)) >> 2);

    // The read is launched on the edge that enters ACK so data lines up with the ack.
    always_comb begin
        ramReadEnable = 1'b0;
        ramIndex      = indexReg;
        if (!rst) begin
            case (state)
                IDLE: begin
                    ramIndex = reqIndex;
                    if (active && validReq && busReadEnableIn && DIRECT_ACK) begin
                        ramReadEnable = 1'b1;
                    end
                end
                WAIT: begin
                    if (active && counter == WAIT_LAST && isReadReg) begin
                        ramReadEnable = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ramWriteEnable = !rst && (state == ACK) && !isReadReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            counter       <= '0;
            indexReg      <= '0;
            isReadReg     <= 1'b0;
            byteEnableReg <= '0;
            writeDataReg  <= '0;
            ackReg        <= 1'b0;
            timeOutReg    <= 1'b0;
        end else begin
            ackReg     <= 1'b0;
            timeOutReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (active) begin
                        indexReg      <= reqIndex;
                        isReadReg     <= busReadEnableIn;
                        byteEnableReg <= busByteEnableIn;
                        writeDataReg  <= busDataIn;
                        if (!validReq) begin
                            state   <= ERR;
                            counter <= CNT_W'(1);
                        end else if (DIRECT_ACK) begin
                            state  <= ACK;
                            ackReg <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            counter <= CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (!active) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else if (counter == WAIT_LAST) begin
                        state   <= ACK;
                        ackReg  <= 1'b1;
                        counter <= '0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                ERR: begin
                    // Stay in ERR through the pulse cycle so a held strobe is not re-accepted.
                    if (timeOutReg || !active) begin
                        state   <= IDLE;
                        counter <= '0;
                    end else if (counter == ERR_LAST) begin
                        timeOutReg <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rmap_bus_ram #(
        .BUS_WIDTH(BUS_WIDTH),
        .WORDS    (NUM_WORDS),
        .INDEX_W  (INDEX_W)
    ) ram (
        .clk        (clk),
        .rst        (rst),
        .index      (ramIndex),
        .writeEnable(ramWriteEnable),
        .byteEnable (byteEnableReg),
        .writeData  (writeDataReg),
        .readEnable (ramReadEnable),
        .readData   (busDataOut)
    );

    assign busAcknowledgeOut  = ackReg;
    assign busTimeOutErrorOut = timeOutReg;

endmodule
